// File: rtl/note_sequencer.sv
// Note sequencer: plays a fixed 14-entry song as a square wave on tone_out,
// holding each entry for its beat count and inserting a silent gap after it.
module note_sequencer #(
  parameter logic [17:0] HALF_C     = 18'd190840,
  parameter logic [17:0] HALF_D     = 18'd170068,
  parameter logic [17:0] HALF_E     = 18'd151515,
  parameter logic [17:0] HALF_F     = 18'd143266,
  parameter logic [17:0] HALF_G     = 18'd127551,
  parameter logic [17:0] HALF_A     = 18'd113636,
  parameter int unsigned GAP_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       beat_clk,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
  output logic       tone_out,
  output logic       busy,
  output logic [3:0] note_idx,
  output logic [2:0] note_code,
  output logic       done
);

  localparam int unsigned      GAP_EFF  = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;
  localparam int               GAP_W    = (GAP_EFF > 1) ? $clog2(GAP_EFF) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_EFF - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [3:0]       LAST_IDX = 4'd13;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  // Song entry as {code[2:0], beats[1:0]}
  function automatic logic [4:0] song_rom(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1:   song_rom = {3'd1, 2'd1};
      4'd2, 4'd3:   song_rom = {3'd5, 2'd1};
      4'd4, 4'd5:   song_rom = {3'd6, 2'd1};
      4'd6:         song_rom = {3'd5, 2'd2};
      4'd7, 4'd8:   song_rom = {3'd4, 2'd1};
      4'd9, 4'd10:  song_rom = {3'd3, 2'd1};
      4'd11, 4'd12: song_rom = {3'd2, 2'd1};
      4'd13:        song_rom = {3'd1, 2'd2};
      default:      song_rom = {3'd0, 2'd1};
    endcase
  endfunction

  function automatic logic [17:0] half_of(input logic [2:0] code);
    case (code)
      3'd1:    half_of = HALF_C;
      3'd2:    half_of = HALF_D;
      3'd3:    half_of = HALF_E;
      3'd4:    half_of = HALF_F;
      3'd5:    half_of = HALF_G;
      3'd6:    half_of = HALF_A;
      default: half_of = 18'd1;
    endcase
  endfunction

  state_t           state, state_nx;
  logic [3:0]       idx_nx;
  logic [1:0]       beat_cnt, beat_nx;
  logic [17:0]      tone_cnt, tone_cnt_nx;
  logic [GAP_W-1:0] gap_cnt, gap_nx;
  logic             tone_nx, done_nx;
  logic             beat_q, beat_rise;
  logic [4:0]       rom_word;
  logic [2:0]       beats_eff;
  logic [17:0]      cur_half;

  assign beat_rise = beat_clk & ~beat_q;
  assign rom_word  = song_rom(note_idx);
  assign note_code = rom_word[4:2];
  assign beats_eff = (rom_word[1:0] == 2'd0) ? 3'd1 : {1'b0, rom_word[1:0]};
  assign cur_half  = half_of(rom_word[4:2]);
  assign busy      = (state != IDLE);

  // Tone counter and output fall back to zero unless a sounding note keeps them running
  always_comb begin
    state_nx    = state;
    idx_nx      = note_idx;
    beat_nx     = beat_cnt;
    gap_nx      = gap_cnt;
    tone_cnt_nx = '0;
    tone_nx     = 1'b0;
    done_nx     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nx = PLAY;
          idx_nx   = '0;
          beat_nx  = '0;
        end
      end
      PLAY: begin
        if (stop) begin
          state_nx = IDLE;
        end else if (beat_rise && (({1'b0, beat_cnt} + 3'd1) == beats_eff)) begin
          state_nx = GAP;
          gap_nx   = '0;
        end else begin
          if (beat_rise) beat_nx = beat_cnt + 2'd1;
          if (note_code != 3'd0) begin
            if (tone_cnt == cur_half - 18'd1) begin
              tone_nx = ~tone_out;
            end else begin
              tone_cnt_nx = tone_cnt + 18'd1;
              tone_nx     = tone_out;
            end
          end
        end
      end
      GAP: begin
        if (stop) begin
          state_nx = IDLE;
        end else if (gap_cnt == GAP_LAST) begin
          beat_nx = '0;
          if (note_idx != LAST_IDX) begin
            idx_nx   = note_idx + 4'd1;
            state_nx = PLAY;
          end else if (loop_en) begin
            idx_nx   = '0;
            state_nx = PLAY;
          end else begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end else begin
          gap_nx = gap_cnt + GAP_ONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      note_idx <= '0;
      beat_cnt <= '0;
      tone_cnt <= '0;
      gap_cnt  <= '0;
      beat_q   <= 1'b0;
      tone_out <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      note_idx <= idx_nx;
      beat_cnt <= beat_nx;
      tone_cnt <= tone_cnt_nx;
      gap_cnt  <= gap_nx;
      beat_q   <= beat_clk;
      tone_out <= tone_nx;
      done     <= done_nx;
    end
  end

endmodule
